// File: rtl/bytes_to_bits_collector_pkg.sv
// Shared definitions for the byte-to-bit collector.
//   b2b_state_t      : collector FSM state (COLLECT accepts bytes, FULL holds a block)
//   KYBER_SYM_BYTES  : 32-byte symmetric block length (common BYTE_LEN)
//   KYBER_POLY_BYTES : 384-byte encoded polynomial length (common BYTE_LEN)
package kyber_pkg;

  localparam int unsigned KYBER_SYM_BYTES  = 32;
  localparam int unsigned KYBER_POLY_BYTES = 384;

  typedef enum logic [0:0] {
    COLLECT,
    FULL
  } b2b_state_t;

endpackage

// File: rtl/bytes_to_bits_collector_if.sv
// Byte-in / block-out handshake bundle for bytes_to_bits_collector.
//   byte_in, byte_valid, byte_ready : byte stream (source -> collector)
//   bit_array, bits_valid, bits_ready : assembled block (collector -> consumer)
// Modports: master = source/consumer side, slave = collector side.
interface bytes_to_bits_collector_if
  import kyber_pkg::*;
#(
  parameter int unsigned BYTE_LEN = KYBER_SYM_BYTES
);

  logic [7:0]            byte_in;
  logic                  byte_valid;
  logic                  byte_ready;
  logic [BYTE_LEN*8-1:0] bit_array;
  logic                  bits_valid;
  logic                  bits_ready;

  modport master (
    output byte_in,
    output byte_valid,
    input  byte_ready,
    input  bit_array,
    input  bits_valid,
    output bits_ready
  );

  modport slave (
    input  byte_in,
    input  byte_valid,
    output byte_ready,
    output bit_array,
    output bits_valid,
    input  bits_ready
  );

endinterface

// File: rtl/bytes_to_bits_collector.sv
// Streaming byte-to-bit collector: assembles BYTE_LEN bytes (one per
// byte handshake) into a flat little-endian bit array, so bit 8*j+k is
// bit k of byte j, and presents it with its own valid/ready handshake.
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset
//   clear : synchronous abort, discards any partial or pending block
//   bus   : slave side of bytes_to_bits_collector_if (byte stream in,
//           assembled block out)
module bytes_to_bits_collector
  import kyber_pkg::*;
#(
  parameter int unsigned BYTE_LEN = KYBER_SYM_BYTES
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear,
  bytes_to_bits_collector_if.slave    bus
);

  if (BYTE_LEN < 2) begin : g_bad_byte_len
    $error("bytes_to_bits_collector: BYTE_LEN must be >= 2");
  end

  localparam int unsigned     CNT_W    = $clog2(BYTE_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTE_LEN - 1);

  b2b_state_t            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q;
  logic [BYTE_LEN*8-1:0] bits_q;
  logic                  byte_ready_w;
  logic                  bits_valid_w;
  logic                  byte_hs;
  logic                  bits_hs;

  // Flags come from registered state only; rst masks them so neither
  // handshake can fire in the first reset cycle.
  always_comb begin
    byte_ready_w = 1'b0;
    bits_valid_w = 1'b0;
    if (!rst) begin
      byte_ready_w = (state_q == COLLECT);
      bits_valid_w = (state_q == FULL);
    end
  end

  assign byte_hs = bus.byte_valid & byte_ready_w;
  assign bits_hs = bus.bits_ready & bits_valid_w;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      COLLECT: if (byte_hs && (cnt_q == CNT_LAST)) state_d = FULL;
      FULL:    if (bits_hs) state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  // State, byte counter and lane write share one register process so that
  // clear/reset wipes all three together and leaves no partial residue.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state_q <= COLLECT;
      cnt_q   <= '0;
      bits_q  <= '0;
    end else begin
      state_q <= state_d;
      if (byte_hs) begin
        bits_q[8*cnt_q +: 8] <= bus.byte_in;
        cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
      end
    end
  end

  assign bus.byte_ready = byte_ready_w;
  assign bus.bits_valid = bits_valid_w;
  assign bus.bit_array  = bits_q;

endmodule
